// File: rtl/pc_shot_engine.sv
// Computer-opponent shooter: picks a pseudo-random unshot cell on the player board,
// marks it hit or miss, and tracks remaining player ships and shots fired.
module pc_shot_engine #(
    parameter logic [7:0] SEED         = 8'hA5,
    parameter int         THINK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pc_turn,
    input  logic       ships_load,
    input  logic [2:0] ships_init,
    input  logic [1:0] cell_rd,
    output logic [2:0] cell_i,
    output logic [2:0] cell_j,
    output logic       cell_we,
    output logic [1:0] cell_wd,
    output logic       shot_done,
    output logic       shot_hit,
    output logic [2:0] player_ships,
    output logic       all_sunk,
    output logic [4:0] shots_fired
);

    typedef enum logic [2:0] {
        IDLE, THINK, PICK, PROBE, WRITE, DONE, WAIT_LOW
    } state_t;

    state_t     state, state_next;
    logic [7:0] think_cnt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_next;
    logic [4:0] cursor;
    logic [4:0] raw_idx;
    logic [4:0] pick_idx;
    logic       probe_hit;
    logic       exhausted;

    // Taps for x^8+x^6+x^5+x^4+1; the freshly advanced value selects the cell.
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign raw_idx   = lfsr_next[4:0];
    assign pick_idx  = (raw_idx >= 5'd25) ? raw_idx - 5'd25 : raw_idx;
    assign exhausted = (shots_fired == 5'd25);

    assign cell_i    = 3'(cursor / 5'd5);
    assign cell_j    = 3'(cursor % 5'd5);
    assign cell_we   = (state == WRITE);
    assign cell_wd   = cell_we ? {1'b1, probe_hit} : 2'b00;
    assign shot_done = (state == DONE);

    // NOTE: always_comb assigns every output a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (pc_turn) state_next = THINK;
            THINK:    if (think_cnt == 8'd1) state_next = PICK;
            PICK:     state_next = exhausted ? DONE : PROBE;
            PROBE:    if (!cell_rd[1]) state_next = WRITE;
            WRITE:    state_next = DONE;
            DONE:     state_next = WAIT_LOW;
            WAIT_LOW: if (!pc_turn) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            think_cnt <= 8'd0;
            lfsr      <= SEED;
            cursor    <= 5'd0;
            probe_hit <= 1'b0;
            shot_hit  <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE:  think_cnt <= 8'(THINK_CYCLES);
                THINK: think_cnt <= think_cnt - 8'd1;
                PICK: begin
                    if (exhausted) begin
                        shot_hit <= 1'b0;
                    end else begin
                        lfsr   <= lfsr_next;
                        cursor <= pick_idx;
                    end
                end
                PROBE: begin
                    if (cell_rd[1]) cursor <= (cursor == 5'd24) ? 5'd0 : cursor + 5'd1;
                    else            probe_hit <= cell_rd[0];
                end
                WRITE:   shot_hit <= probe_hit;
                default: ;
            endcase
        end
    end

    // A new game's load overrides any same-cycle shot bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_ships <= 3'd0;
            all_sunk     <= 1'b1;
            shots_fired  <= 5'd0;
        end else if (ships_load) begin
            player_ships <= ships_init;
            all_sunk     <= (ships_init == 3'd0);
            shots_fired  <= 5'd0;
        end else if (state == WRITE) begin
            shots_fired <= shots_fired + 5'd1;
            if (probe_hit && player_ships != 3'd0) begin
                player_ships <= player_ships - 3'd1;
                all_sunk     <= (player_ships == 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_pc_shot_engine.sv
// Scoreboard bench for pc_shot_engine: a behavioural board + LFSR model predicts each shot,
// and a negedge monitor compares writes and completions against the queued predictions.
module tb_pc_shot_engine;
    localparam logic [7:0] SEED  = 8'h01;
    localparam int         THINK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pc_turn = 1'b0;
    logic       ships_load = 1'b0;
    logic [2:0] ships_init = 3'd0;
    logic [1:0] cell_rd;
    logic [2:0] cell_i, cell_j;
    logic       cell_we;
    logic [1:0] cell_wd;
    logic       shot_done, shot_hit;
    logic [2:0] player_ships;
    logic       all_sunk;
    logic [4:0] shots_fired;

    pc_shot_engine #(.SEED(SEED), .THINK_CYCLES(THINK)) dut (
        .clk(clk), .rst(rst), .pc_turn(pc_turn), .ships_load(ships_load),
        .ships_init(ships_init), .cell_rd(cell_rd), .cell_i(cell_i), .cell_j(cell_j),
        .cell_we(cell_we), .cell_wd(cell_wd), .shot_done(shot_done), .shot_hit(shot_hit),
        .player_ships(player_ships), .all_sunk(all_sunk), .shots_fired(shots_fired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Board storage model: combinational read, write on the clock edge.
    logic [1:0] board [25];
    logic       fill_req = 1'b0;
    logic [1:0] fill_val = 2'b00;
    logic [1:0] fill_c0  = 2'b00;
    int         cur_idx;

    always_comb begin
        cell_rd = 2'b00;
        cur_idx = int'(cell_i) * 5 + int'(cell_j);
        if (cur_idx < 25) cell_rd = board[cur_idx];
    end

    always @(posedge clk) begin
        if (fill_req) begin
            for (int k = 0; k < 25; k++) board[k] <= (k == 0) ? fill_c0 : fill_val;
        end else if (cell_we && cur_idx < 25) begin
            board[cur_idx] <= cell_wd;
        end
    end

    typedef struct {
        int       t0;
        bit       exp_we;
        int       wr_off;
        int       wc;
        int       wd;
        int       done_off;
        int       hit;
        int       ships;
        int       sunk;
        int       fired;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;

    logic [7:0] m_lfsr = SEED;
    int         m_ships = 0;
    int         m_fired = 0;
    int         m_last_r = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int model_map(input logic [7:0] s);
        int r;
        r = int'(s[4:0]);
        return (r >= 25) ? r - 25 : r;
    endfunction

    always @(negedge clk) begin
        if (cell_we) begin
            if (q.size() == 0 || !q[0].exp_we) begin
                check("we_unexpected", int'(cell_we), 0);
            end else begin
                check("we_cycle", cyc, q[0].t0 + q[0].wr_off);
                check("we_cell", cur_idx, q[0].wc);
                check("we_data", int'(cell_wd), q[0].wd);
            end
        end else if (cell_wd != 2'b00) begin
            check("wd_idle", int'(cell_wd), 0);
        end
        if (shot_done) begin
            if (q.size() == 0) begin
                check("done_unexpected", int'(shot_done), 0);
            end else begin
                mon_e = q.pop_front();
                check("done_cycle", cyc, mon_e.t0 + mon_e.done_off);
                check("shot_hit", int'(shot_hit), mon_e.hit);
                check("player_ships", int'(player_ships), mon_e.ships);
                check("all_sunk", int'(all_sunk), mon_e.sunk);
                check("shots_fired", int'(shots_fired), mon_e.fired);
            end
            done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_board(input logic [1:0] v, input logic [1:0] v0);
        fill_val = v;
        fill_c0  = v0;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        tick();
    endtask

    task automatic load_ships(input int v);
        ships_init = 3'(v);
        ships_load = 1'b1;
        tick();
        ships_load = 1'b0;
        m_ships = v;
        m_fired = 0;
    endtask

    // Predict the shot from the current board model, queue it, then raise pc_turn.
    task automatic start_shot(input bit load_at_wr, input int load_val, output int wr_cycle);
        exp_t e;
        int   c;
        int   skips;
        e.t0 = cyc;
        if (m_fired == 25) begin
            e.exp_we = 1'b0; e.wr_off = 0; e.wc = 0; e.wd = 0;
            e.done_off = THINK + 2;
            e.hit = 0;
        end else begin
            m_lfsr   = model_step(m_lfsr);
            m_last_r = int'(m_lfsr[4:0]);
            c = model_map(m_lfsr);
            skips = 0;
            while (board[c][1] && skips < 25) begin
                c = (c == 24) ? 0 : c + 1;
                skips++;
            end
            e.exp_we   = 1'b1;
            e.wc       = c;
            e.hit      = (board[c] == 2'b01) ? 1 : 0;
            e.wd       = e.hit ? 3 : 2;
            e.wr_off   = THINK + 3 + skips;
            e.done_off = THINK + 4 + skips;
            m_fired++;
            if (e.hit == 1 && m_ships > 0) m_ships--;
        end
        if (load_at_wr) begin
            m_ships = load_val;
            m_fired = 0;
        end
        e.ships  = m_ships;
        e.sunk   = (m_ships == 0) ? 1 : 0;
        e.fired  = m_fired;
        wr_cycle = e.t0 + e.wr_off;
        q.push_back(e);
        pc_turn = 1'b1;
    endtask

    task automatic wait_done(input int max_cycles);
        int prev;
        prev = done_cnt;
        for (int k = 0; k < max_cycles; k++) begin
            tick();
            if (done_cnt != prev) break;
        end
        check("done_seen", done_cnt - prev, 1);
        if (done_cnt == prev && q.size() > 0) q.delete(0);
    endtask

    task automatic finish_turn();
        pc_turn = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_shot();
        int w;
        start_shot(1'b0, 0, w);
        wait_done(80);
        finish_turn();
    endtask

    task automatic check_reset_outputs();
        check("rst_cell_i", int'(cell_i), 0);
        check("rst_cell_j", int'(cell_j), 0);
        check("rst_cell_we", int'(cell_we), 0);
        check("rst_cell_wd", int'(cell_wd), 0);
        check("rst_shot_done", int'(shot_done), 0);
        check("rst_shot_hit", int'(shot_hit), 0);
        check("rst_player_ships", int'(player_ships), 0);
        check("rst_all_sunk", int'(all_sunk), 1);
        check("rst_shots_fired", int'(shots_fired), 0);
    endtask

    initial begin
        int   prev;
        int   w;
        int   c;
        int   cnt;
        bit [6:0] seen;

        // Power-on reset
        rst = 1'b0;
        fill_board(2'b00, 2'b00);
        check_reset_outputs();
        rst = 1'b1;
        tick();

        // Hit path: all-ship board, one shot while pc_turn stays high
        fill_board(2'b01, 2'b01);
        load_ships(5);
        start_shot(1'b0, 0, w);
        wait_done(80);
        prev = done_cnt;
        repeat (20) tick();
        check("no_second_shot", done_cnt, prev);
        check("hit_ships_4", int'(player_ships), 4);
        check("hit_fired_1", int'(shots_fired), 1);
        finish_turn();
        do_shot();

        // Reset mid-THINK with pc_turn held; new shot starts after release
        fill_board(2'b00, 2'b00);
        pc_turn = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        check("rst_hold_we", int'(cell_we), 0);
        tick();
        rst = 1'b1;
        m_lfsr = SEED;
        m_ships = 0;
        m_fired = 0;
        start_shot(1'b0, 0, w);
        wait_done(80);
        finish_turn();

        // Skip and wrap: only cell (0,0) unshot, start cell must be non-zero
        load_ships(5);
        for (int t = 0; t < 10; t++) begin
            fill_board(2'b10, 2'b00);
            c = model_map(model_step(m_lfsr));
            do_shot();
            if (c != 0) break;
        end
        check("wrap_cell0_miss", int'(board[0]), 2);

        // Exhaustion: 25 misses fill the board, the 26th turn writes nothing
        load_ships(2);
        fill_board(2'b00, 2'b00);
        repeat (25) do_shot();
        cnt = 0;
        for (int k = 0; k < 25; k++) if (board[k] == 2'b10) cnt++;
        check("board_all_miss", cnt, 25);
        check("fired_25", int'(shots_fired), 25);
        do_shot();

        // Counter corners: last ship, saturation, load coincident with a hit write
        fill_board(2'b01, 2'b01);
        load_ships(1);
        do_shot();
        check("last_ship_zero", int'(player_ships), 0);
        check("last_ship_sunk", int'(all_sunk), 1);
        do_shot();
        check("ships_saturate", int'(player_ships), 0);
        start_shot(1'b1, 3, w);
        for (int k = 0; k < 80 && cyc < w; k++) tick();
        ships_init = 3'd3;
        ships_load = 1'b1;
        tick();
        ships_load = 1'b0;
        wait_done(80);
        finish_turn();
        check("load_wins_ships", int'(player_ships), 3);
        check("load_wins_fired", int'(shots_fired), 0);

        // LFSR mapping over at least 50 picks, until every raw index >= 25 has appeared
        seen = '0;
        for (int n = 0; n < 300; n++) begin
            if (n >= 50 && &seen) break;
            fill_board(2'b00, 2'b00);
            load_ships(5);
            do_shot();
            if (m_last_r >= 25) seen[m_last_r - 25] = 1'b1;
        end

        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
